// File: rtl/axi4_mmio_scratchpad.sv
// AXI4 responder that backs a DEPTH x 64-bit register scratchpad at BASE_ADDR.
// Read and write channels are handled by independent single-outstanding FSMs
// and support FIXED, INCR and WRAP bursts.
//
// Ports:
//   clk, resetn          sole clock (rising edge), asynchronous active-low reset
//   S_AXI_aw*            write address (lock/cache/prot/qos ignored)
//   S_AXI_w*             write data with byte strobes
//   S_AXI_b*             write response
//   S_AXI_ar*            read address (lock/cache/prot/qos ignored)
//   S_AXI_r*             read data
// All outputs are driven straight from flops.
module axi4_mmio_scratchpad #(
  parameter logic [30:0] BASE_ADDR = 31'h6000_0000,
  parameter int unsigned DEPTH     = 512
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        S_AXI_awvalid,
  output logic        S_AXI_awready,
  input  logic [4:0]  S_AXI_awid,
  input  logic [30:0] S_AXI_awaddr,
  input  logic [7:0]  S_AXI_awlen,
  input  logic [2:0]  S_AXI_awsize,
  input  logic [1:0]  S_AXI_awburst,
  input  logic        S_AXI_awlock,
  input  logic [3:0]  S_AXI_awcache,
  input  logic [2:0]  S_AXI_awprot,
  input  logic [3:0]  S_AXI_awqos,
  input  logic        S_AXI_wvalid,
  output logic        S_AXI_wready,
  input  logic [63:0] S_AXI_wdata,
  input  logic [7:0]  S_AXI_wstrb,
  input  logic        S_AXI_wlast,
  output logic        S_AXI_bvalid,
  input  logic        S_AXI_bready,
  output logic [4:0]  S_AXI_bid,
  output logic [1:0]  S_AXI_bresp,
  input  logic        S_AXI_arvalid,
  output logic        S_AXI_arready,
  input  logic [4:0]  S_AXI_arid,
  input  logic [30:0] S_AXI_araddr,
  input  logic [7:0]  S_AXI_arlen,
  input  logic [2:0]  S_AXI_arsize,
  input  logic [1:0]  S_AXI_arburst,
  input  logic        S_AXI_arlock,
  input  logic [3:0]  S_AXI_arcache,
  input  logic [2:0]  S_AXI_arprot,
  input  logic [3:0]  S_AXI_arqos,
  output logic        S_AXI_rvalid,
  input  logic        S_AXI_rready,
  output logic [4:0]  S_AXI_rid,
  output logic [63:0] S_AXI_rdata,
  output logic [1:0]  S_AXI_rresp,
  output logic        S_AXI_rlast
);

  localparam int unsigned IdxW      = $clog2(DEPTH);
  localparam logic [31:0] LimitAddr = {1'b0, BASE_ADDR} + 32'(DEPTH * 8);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;
  localparam logic [1:0]  RespDecerr = 2'b11;
  localparam logic [1:0]  BurstFixed = 2'b00;
  localparam logic [1:0]  BurstWrap  = 2'b10;
  localparam logic [1:0]  BurstRsvd  = 2'b11;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  logic [63:0] mem [DEPTH];

  logic unused_sideband;
  assign unused_sideband = ^{S_AXI_awlock, S_AXI_awcache, S_AXI_awprot, S_AXI_awqos,
                             S_AXI_arlock, S_AXI_arcache, S_AXI_arprot, S_AXI_arqos};

  // Byte address of the beat following addr. WRAP keeps the low bits inside the
  // (len+1)<<size block; reserved bursts advance like INCR.
  function automatic logic [30:0] next_addr(input logic [30:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [30:0] incr;
    logic [30:0] mask;
    incr = 31'd1 << size;
    mask = ((31'(len) + 31'd1) << size) - 31'd1;
    case (burst)
      BurstFixed: return addr;
      BurstWrap:  return (addr & ~mask) | ((addr + incr) & mask);
      default:    return addr + incr;
    endcase
  endfunction

  function automatic logic in_range(input logic [30:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LimitAddr);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [30:0] addr);
    return IdxW'((addr - BASE_ADDR) >> 3);
  endfunction

  // ---------------------------------------------------------------- write path
  w_state_e    w_state_q, w_state_d;
  logic [4:0]  aw_id_q;
  logic [30:0] aw_addr_q;
  logic [7:0]  aw_len_q, w_cnt_q;
  logic [2:0]  aw_size_q;
  logic [1:0]  aw_burst_q;
  logic        w_dec_q, w_slv_q;

  logic           aw_hs, w_hs, b_hs;
  logic           w_in_range, w_beat_ok, w_last_beat, w_dec_d, w_slv_d;
  logic [IdxW-1:0] w_idx;
  logic [63:0]    w_merged;

  assign aw_hs       = S_AXI_awvalid && S_AXI_awready;
  assign w_hs        = S_AXI_wvalid && S_AXI_wready;
  assign b_hs        = S_AXI_bvalid && S_AXI_bready;
  assign w_in_range  = in_range(aw_addr_q);
  assign w_beat_ok   = w_in_range && (aw_size_q <= 3'd3);
  assign w_last_beat = (w_cnt_q == aw_len_q);
  assign w_dec_d     = w_dec_q || !w_in_range;
  assign w_slv_d     = w_slv_q || (aw_size_q > 3'd3) || (aw_burst_q == BurstRsvd) ||
                       (S_AXI_wlast != w_last_beat);
  assign w_idx       = word_idx(aw_addr_q);

  always_comb begin
    w_merged = mem[w_idx];
    for (int b = 0; b < 8; b++) begin
      if (S_AXI_wstrb[b]) w_merged[8*b +: 8] = S_AXI_wdata[8*b +: 8];
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_hs) w_state_d = WData;
      WData:   if (w_hs && w_last_beat) w_state_d = WResp;
      WResp:   if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q     <= WIdle;
      S_AXI_awready <= 1'b0;
      S_AXI_wready  <= 1'b0;
      S_AXI_bvalid  <= 1'b0;
      S_AXI_bid     <= '0;
      S_AXI_bresp   <= RespOkay;
      aw_id_q       <= '0;
      aw_addr_q     <= '0;
      aw_len_q      <= '0;
      aw_size_q     <= '0;
      aw_burst_q    <= '0;
      w_cnt_q       <= '0;
      w_dec_q       <= 1'b0;
      w_slv_q       <= 1'b0;
    end else begin
      w_state_q     <= w_state_d;
      S_AXI_awready <= (w_state_d == WIdle);
      S_AXI_wready  <= (w_state_d == WData);
      S_AXI_bvalid  <= (w_state_d == WResp);
      if (aw_hs) begin
        aw_id_q    <= S_AXI_awid;
        aw_addr_q  <= S_AXI_awaddr;
        aw_len_q   <= S_AXI_awlen;
        aw_size_q  <= S_AXI_awsize;
        aw_burst_q <= S_AXI_awburst;
        w_cnt_q    <= '0;
        w_dec_q    <= 1'b0;
        w_slv_q    <= 1'b0;
      end else if (w_hs) begin
        aw_addr_q <= next_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q);
        w_cnt_q   <= w_cnt_q + 8'd1;
        w_dec_q   <= w_dec_d;
        w_slv_q   <= w_slv_d;
        if (w_last_beat) begin
          S_AXI_bid   <= aw_id_q;
          S_AXI_bresp <= w_dec_d ? RespDecerr : (w_slv_d ? RespSlverr : RespOkay);
        end
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_hs && w_beat_ok) mem[w_idx] <= w_merged;
  end

  // ----------------------------------------------------------------- read path
  r_state_e    r_state_q, r_state_d;
  logic [30:0] ar_addr_q;
  logic [7:0]  ar_len_q, r_cnt_q;
  logic [2:0]  ar_size_q;
  logic [1:0]  ar_burst_q;

  logic        ar_hs, r_hs, r_last_beat, r_ld_dec, r_ld_slv;
  logic [30:0] r_ld_addr;
  logic [2:0]  r_ld_size;
  logic [1:0]  r_ld_burst, r_ld_resp;
  logic [63:0] r_ld_data;

  assign ar_hs       = S_AXI_arvalid && S_AXI_arready;
  assign r_hs        = S_AXI_rvalid && S_AXI_rready;
  assign r_last_beat = (r_cnt_q == ar_len_q);

  // Beat to load into the R output flops: the AR address on a new burst,
  // otherwise the advanced address. mem is read pre-edge, so a same-edge write
  // only shows up on a later beat.
  always_comb begin
    r_ld_addr  = ar_hs ? S_AXI_araddr : next_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);
    r_ld_size  = ar_hs ? S_AXI_arsize : ar_size_q;
    r_ld_burst = ar_hs ? S_AXI_arburst : ar_burst_q;
    r_ld_dec   = !in_range(r_ld_addr);
    r_ld_slv   = (r_ld_size > 3'd3) || (r_ld_burst == BurstRsvd);
    r_ld_resp  = r_ld_dec ? RespDecerr : (r_ld_slv ? RespSlverr : RespOkay);
    r_ld_data  = (r_ld_dec || r_ld_slv) ? 64'd0 : mem[word_idx(r_ld_addr)];
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RData;
      RData:   if (r_hs && r_last_beat) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q     <= RIdle;
      S_AXI_arready <= 1'b0;
      S_AXI_rvalid  <= 1'b0;
      S_AXI_rlast   <= 1'b0;
      S_AXI_rid     <= '0;
      S_AXI_rdata   <= '0;
      S_AXI_rresp   <= RespOkay;
      ar_addr_q     <= '0;
      ar_len_q      <= '0;
      ar_size_q     <= '0;
      ar_burst_q    <= '0;
      r_cnt_q       <= '0;
    end else begin
      r_state_q     <= r_state_d;
      S_AXI_arready <= (r_state_d == RIdle);
      S_AXI_rvalid  <= (r_state_d == RData);
      if (ar_hs) begin
        ar_addr_q   <= S_AXI_araddr;
        ar_len_q    <= S_AXI_arlen;
        ar_size_q   <= S_AXI_arsize;
        ar_burst_q  <= S_AXI_arburst;
        r_cnt_q     <= '0;
        S_AXI_rid   <= S_AXI_arid;
        S_AXI_rdata <= r_ld_data;
        S_AXI_rresp <= r_ld_resp;
        S_AXI_rlast <= (S_AXI_arlen == 8'd0);
      end else if (r_hs) begin
        if (r_last_beat) begin
          S_AXI_rlast <= 1'b0;
        end else begin
          ar_addr_q   <= r_ld_addr;
          r_cnt_q     <= r_cnt_q + 8'd1;
          S_AXI_rdata <= r_ld_data;
          S_AXI_rresp <= r_ld_resp;
          S_AXI_rlast <= ((r_cnt_q + 8'd1) == ar_len_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_mmio_scratchpad.sv
module tb_axi4_mmio_scratchpad;

  localparam logic [30:0] Base   = 31'h6000_0000;
  localparam int unsigned Depth  = 512;
  localparam logic [1:0]  Okay   = 2'b00;
  localparam logic [1:0]  Slverr = 2'b10;
  localparam logic [1:0]  Decerr = 2'b11;
  localparam logic [1:0]  Incr   = 2'b01;
  localparam logic [1:0]  Wrap   = 2'b10;
  localparam logic [1:0]  Rsvd   = 2'b11;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        S_AXI_awvalid = 1'b0, S_AXI_awready;
  logic [4:0]  S_AXI_awid = '0;
  logic [30:0] S_AXI_awaddr = '0;
  logic [7:0]  S_AXI_awlen = '0;
  logic [2:0]  S_AXI_awsize = '0;
  logic [1:0]  S_AXI_awburst = '0;
  logic        S_AXI_wvalid = 1'b0, S_AXI_wready;
  logic [63:0] S_AXI_wdata = '0;
  logic [7:0]  S_AXI_wstrb = '0;
  logic        S_AXI_wlast = 1'b0;
  logic        S_AXI_bvalid, S_AXI_bready = 1'b0;
  logic [4:0]  S_AXI_bid;
  logic [1:0]  S_AXI_bresp;
  logic        S_AXI_arvalid = 1'b0, S_AXI_arready;
  logic [4:0]  S_AXI_arid = '0;
  logic [30:0] S_AXI_araddr = '0;
  logic [7:0]  S_AXI_arlen = '0;
  logic [2:0]  S_AXI_arsize = '0;
  logic [1:0]  S_AXI_arburst = '0;
  logic        S_AXI_rvalid, S_AXI_rready = 1'b0;
  logic [4:0]  S_AXI_rid;
  logic [63:0] S_AXI_rdata;
  logic [1:0]  S_AXI_rresp;
  logic        S_AXI_rlast;

  axi4_mmio_scratchpad #(.BASE_ADDR(Base), .DEPTH(Depth)) dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready), .S_AXI_awid(S_AXI_awid),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen), .S_AXI_awsize(S_AXI_awsize),
    .S_AXI_awburst(S_AXI_awburst), .S_AXI_awlock(1'b0), .S_AXI_awcache(4'd0),
    .S_AXI_awprot(3'd0), .S_AXI_awqos(4'd0),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready), .S_AXI_wdata(S_AXI_wdata),
    .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
    .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready), .S_AXI_bid(S_AXI_bid),
    .S_AXI_bresp(S_AXI_bresp),
    .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready), .S_AXI_arid(S_AXI_arid),
    .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen), .S_AXI_arsize(S_AXI_arsize),
    .S_AXI_arburst(S_AXI_arburst), .S_AXI_arlock(1'b0), .S_AXI_arcache(4'd0),
    .S_AXI_arprot(3'd0), .S_AXI_arqos(4'd0),
    .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready), .S_AXI_rid(S_AXI_rid),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rlast(S_AXI_rlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] id;
    logic [1:0] resp;
  } bexp_t;

  typedef struct {
    logic [4:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [30:0] waddr;
    logic [2:0]  wsize;
    logic [1:0]  burst;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp;
    logic [30:0] raddr;
    logic [63:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  bexp_t b_exp[$];
  rexp_t r_exp[$];
  bexp_t be;
  rexp_t re;
  logic [63:0] wdat [16];
  logic [7:0]  wstb [16];
  vec_t vecs [12];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic push_r(input logic [4:0] id, input logic [63:0] data, input logic [1:0] resp,
                        input logic last);
    r_exp.push_back('{id, data, resp, last});
  endtask

  // Scoreboard: B/R responses are compared against queue heads at each handshake;
  // a stalled R beat must already show the data expected at the queue head.
  always @(negedge clk) begin
    if (resetn && S_AXI_bvalid && S_AXI_bready) begin
      if (b_exp.size() == 0) fail_now("b_unexpected");
      else begin
        be = b_exp.pop_front();
        chk("bid", 64'(S_AXI_bid), 64'(be.id));
        chk("bresp", 64'(S_AXI_bresp), 64'(be.resp));
      end
    end
    if (resetn && S_AXI_rvalid) begin
      if (r_exp.size() == 0) fail_now("r_unexpected");
      else if (S_AXI_rready) begin
        re = r_exp.pop_front();
        chk("rid", 64'(S_AXI_rid), 64'(re.id));
        chk("rdata", S_AXI_rdata, re.data);
        chk("rresp", 64'(S_AXI_rresp), 64'(re.resp));
        chk("rlast", 64'(S_AXI_rlast), 64'(re.last));
      end else begin
        chk("r_stall_data", S_AXI_rdata, r_exp[0].data);
        chk("r_stall_last", 64'(S_AXI_rlast), 64'(r_exp[0].last));
      end
    end
  end

  task automatic do_aw(input logic [4:0] id, input logic [30:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    S_AXI_awvalid = 1'b1;
    S_AXI_awid    = id;
    S_AXI_awaddr  = addr;
    S_AXI_awlen   = len;
    S_AXI_awsize  = size;
    S_AXI_awburst = burst;
    n = 0;
    while (!S_AXI_awready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) fail_now("aw_wait");
    @(posedge clk); #1;
    S_AXI_awvalid = 1'b0;
  endtask

  task automatic do_w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n;
    S_AXI_wvalid = 1'b1;
    S_AXI_wdata  = data;
    S_AXI_wstrb  = strb;
    S_AXI_wlast  = last;
    n = 0;
    while (!S_AXI_wready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) fail_now("w_wait");
    @(posedge clk); #1;
    S_AXI_wvalid = 1'b0;
    S_AXI_wlast  = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] id, input logic [30:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [1:0] resp, input int bdelay);
    int n;
    b_exp.push_back('{id, resp});
    do_aw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) do_w_beat(wdat[i], wstb[i], i == int'(len));
    // bvalid must be up the cycle after the last W and hold while bready is low
    for (int i = 0; i < bdelay; i++) begin
      chk("bvalid_hold", 64'(S_AXI_bvalid), 64'(1));
      @(posedge clk); #1;
    end
    S_AXI_bready = 1'b1;
    n = 0;
    while (b_exp.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin fail_now("b_wait"); b_exp.delete(); end
    S_AXI_bready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] id, input logic [30:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [7:0] rpat);
    int n;
    S_AXI_arvalid = 1'b1;
    S_AXI_arid    = id;
    S_AXI_araddr  = addr;
    S_AXI_arlen   = len;
    S_AXI_arsize  = size;
    S_AXI_arburst = burst;
    n = 0;
    while (!S_AXI_arready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) fail_now("ar_wait");
    @(posedge clk); #1;
    S_AXI_arvalid = 1'b0;
    chk("rvalid_after_ar", 64'(S_AXI_rvalid), 64'(1));
    chk("arready_busy", 64'(S_AXI_arready), 64'(0));
    n = 0;
    while (r_exp.size() != 0 && n < 100) begin
      S_AXI_rready = rpat[3'(n)];
      @(posedge clk); #1;
      n++;
    end
    S_AXI_rready = 1'b0;
    if (n == 100) begin fail_now("r_wait"); r_exp.delete(); end
    chk("arready_after_last", 64'(S_AXI_arready), 64'(1));
    chk("rvalid_after_last", 64'(S_AXI_rvalid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //           waddr          sz  burst  wdata                   strb   bresp   raddr          rdata                   rresp
    vecs[0]  = '{Base + 31'h10,  3, Incr, 64'hDEADBEEF_01234567, 8'hFF, Okay,   Base + 31'h10,  64'hDEADBEEF_01234567, Okay};
    vecs[1]  = '{Base,           3, Incr, 64'h0,                 8'hFF, Okay,   Base,           64'h0,                 Okay};
    vecs[2]  = '{Base + 31'h3,   0, Incr, 64'h00000000_AA000000, 8'h08, Okay,   Base,           64'h00000000_AA000000, Okay};
    vecs[3]  = '{Base + 31'h20,  3, Incr, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, Okay,   Base + 31'h20,  64'hFFFFFFFF_FFFFFFFF, Okay};
    vecs[4]  = '{Base + 31'h20,  3, Incr, 64'h0,                 8'h0F, Okay,   Base + 31'h20,  64'hFFFFFFFF_00000000, Okay};
    vecs[5]  = '{Base + 31'h28,  3, Incr, 64'h1111,              8'hFF, Okay,   Base + 31'h28,  64'h1111,              Okay};
    vecs[6]  = '{Base + 31'h28,  4, Incr, 64'h2222,              8'hFF, Slverr, Base + 31'h28,  64'h1111,              Okay};
    vecs[7]  = '{Base + 31'h1000, 3, Incr, 64'h5555,             8'hFF, Decerr, Base + 31'h1000, 64'h0,                Decerr};
    vecs[8]  = '{Base + 31'hFF8, 3, Incr, 64'hCAFEF00D_12345678, 8'hFF, Okay,   Base + 31'hFF8, 64'hCAFEF00D_12345678, Okay};
    vecs[9]  = '{Base - 31'h8,   3, Incr, 64'h7777,              8'hFF, Decerr, Base - 31'h8,   64'h0,                 Decerr};
    vecs[10] = '{Base + 31'h8,   3, Rsvd, 64'h01234567_89ABCDEF, 8'hFF, Slverr, Base + 31'h8,   64'h0,                 Slverr};
    vecs[11] = '{Base + 31'h8,   3, Incr, 64'hFFFF,              8'h00, Okay,   Base + 31'h8,   64'h01234567_89ABCDEF, Okay};

    // Reset values, then ready rises on the first edge after release.
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 64'(S_AXI_awready), 64'(0));
    chk("rst_arready", 64'(S_AXI_arready), 64'(0));
    chk("rst_wready", 64'(S_AXI_wready), 64'(0));
    chk("rst_bvalid", 64'(S_AXI_bvalid), 64'(0));
    chk("rst_rvalid", 64'(S_AXI_rvalid), 64'(0));
    chk("rst_rlast", 64'(S_AXI_rlast), 64'(0));
    chk("rst_rdata", S_AXI_rdata, 64'(0));
    chk("rst_ids", 64'({S_AXI_bid, S_AXI_rid, S_AXI_bresp, S_AXI_rresp}), 64'(0));
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("rel_awready", 64'(S_AXI_awready), 64'(1));
    chk("rel_arready", 64'(S_AXI_arready), 64'(1));

    // Single-beat write/read-back vectors.
    for (int i = 0; i < 12; i++) begin
      wdat[0] = vecs[i].wdata;
      wstb[0] = vecs[i].wstrb;
      do_write(5'(i), vecs[i].waddr, 8'd0, vecs[i].wsize, vecs[i].burst, vecs[i].bresp, 0);
      push_r(5'(i + 16), vecs[i].rdata, vecs[i].rresp, 1'b1);
      do_read(5'(i + 16), vecs[i].raddr, 8'd0, 3'd3, vecs[i].burst, 8'hFF);
    end

    // INCR write 1..4 at Base, then WRAP read from Base+0x10 -> 3,4,1,2.
    for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; end
    do_write(5'd3, Base, 8'd3, 3'd3, Incr, Okay, 0);
    push_r(5'd4, 64'd3, Okay, 1'b0);
    push_r(5'd4, 64'd4, Okay, 1'b0);
    push_r(5'd4, 64'd1, Okay, 1'b0);
    push_r(5'd4, 64'd2, Okay, 1'b1);
    do_read(5'd4, Base + 31'h10, 8'd3, 3'd3, Wrap, 8'hFF);

    // INCR read running off the end of the window.
    push_r(5'd5, 64'hCAFEF00D_12345678, Okay, 1'b0);
    push_r(5'd5, 64'd0, Decerr, 1'b1);
    do_read(5'd5, Base + 31'hFF8, 8'd1, 3'd3, Incr, 8'hFF);

    // Backpressure: rready 1,0,0,1,... and bready low for 5 cycles.
    for (int i = 0; i < 4; i++) push_r(5'd6, 64'(i + 1), Okay, i == 3);
    do_read(5'd6, Base, 8'd3, 3'd3, Incr, 8'b1111_1001);
    wdat[0] = 64'hABCD;
    wstb[0] = 8'hFF;
    do_write(5'd7, Base + 31'h30, 8'd0, 3'd3, Incr, Okay, 5);
    push_r(5'd8, 64'hABCD, Okay, 1'b1);
    do_read(5'd8, Base + 31'h30, 8'd0, 3'd3, Incr, 8'hFF);

    // Same-edge W and AR handshakes on one word: the read sees the old value.
    b_exp.push_back('{5'd10, Okay});
    push_r(5'd11, 64'h1111, Okay, 1'b1);
    do_aw(5'd10, Base + 31'h28, 8'd0, 3'd3, Incr);
    S_AXI_wvalid  = 1'b1;
    S_AXI_wdata   = 64'h9999;
    S_AXI_wstrb   = 8'hFF;
    S_AXI_wlast   = 1'b1;
    S_AXI_arvalid = 1'b1;
    S_AXI_arid    = 5'd11;
    S_AXI_araddr  = Base + 31'h28;
    S_AXI_arlen   = 8'd0;
    S_AXI_arsize  = 3'd3;
    S_AXI_arburst = Incr;
    S_AXI_rready  = 1'b1;
    S_AXI_bready  = 1'b1;
    chk("same_edge_wready", 64'(S_AXI_wready), 64'(1));
    chk("same_edge_arready", 64'(S_AXI_arready), 64'(1));
    @(posedge clk); #1;
    S_AXI_wvalid  = 1'b0;
    S_AXI_wlast   = 1'b0;
    S_AXI_arvalid = 1'b0;
    n = 0;
    while ((b_exp.size() != 0 || r_exp.size() != 0) && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin fail_now("same_edge_wait"); b_exp.delete(); r_exp.delete(); end
    S_AXI_rready = 1'b0;
    S_AXI_bready = 1'b0;
    push_r(5'd12, 64'h9999, Okay, 1'b1);
    do_read(5'd12, Base + 31'h28, 8'd0, 3'd3, Incr, 8'hFF);

    // Reset in the middle of a len=7 write; the response is dropped.
    do_aw(5'd9, Base + 31'h40, 8'd7, 3'd3, Incr);
    for (int i = 0; i < 3; i++) do_w_beat(64'h100 + 64'(i), 8'hFF, 1'b0);
    resetn = 1'b0;
    #1;
    chk("midrst_bvalid", 64'(S_AXI_bvalid), 64'(0));
    chk("midrst_wready", 64'(S_AXI_wready), 64'(0));
    chk("midrst_awready", 64'(S_AXI_awready), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("postrst_awready", 64'(S_AXI_awready), 64'(1));
    chk("postrst_bvalid", 64'(S_AXI_bvalid), 64'(0));
    chk("postrst_wready", 64'(S_AXI_wready), 64'(0));
    for (int i = 0; i < 3; i++) push_r(5'd13, 64'h100 + 64'(i), Okay, i == 2);
    do_read(5'd13, Base + 31'h40, 8'd2, 3'd3, Incr, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
